// File: rtl/adpll_lock_ctrl_if.sv
// Phase-detector error sample bus feeding the ADPLL lock controller.
interface adpll_lock_ctrl_if #(
    parameter int unsigned ERROR_WIDTH = 8
);
    logic                          error_valid_i;
    logic signed [ERROR_WIDTH-1:0] error_i;

    modport master (output error_valid_i, error_i);
    modport slave  (input  error_valid_i, error_i);
endinterface

// File: rtl/adpll_lock_ctrl.sv
// Lock sequencer for a ring-oscillator ADPLL: reset, warm-up, acquisition with
// wide gains, tracking with narrow gains, lock-loss detection and timeout.
module adpll_lock_ctrl #(
    parameter int unsigned          ERROR_WIDTH   = 8,
    parameter int unsigned          KP_WIDTH      = 4,
    parameter int unsigned          KI_WIDTH      = 4,
    parameter logic [KP_WIDTH-1:0]  KP_ACQ        = 4'b0100,
    parameter logic [KI_WIDTH-1:0]  KI_ACQ        = 4'b0010,
    parameter logic [KP_WIDTH-1:0]  KP_TRK        = 4'b0010,
    parameter logic [KI_WIDTH-1:0]  KI_TRK        = 4'b0001,
    parameter int unsigned          RST_CYCLES    = 16,
    parameter int unsigned          WARMUP_CYCLES = 64,
    parameter int unsigned          ACQ_THRESH    = 2,
    parameter int unsigned          UNLOCK_THRESH = 8,
    parameter int unsigned          ACQ_COUNT     = 8,
    parameter int unsigned          UNLOCK_COUNT  = 4,
    parameter int unsigned          ACQ_TIMEOUT   = 255
) (
    input  logic                    fpga_clk_i,
    input  logic                    reset_i,
    input  logic                    start_i,
    adpll_lock_ctrl_if.slave        err_if,
    output logic                    pll_reset_o,
    output logic                    ring_enable_o,
    output logic [KP_WIDTH-1:0]     kp_o,
    output logic [KI_WIDTH-1:0]     ki_o,
    output logic                    locked_o,
    output logic                    fail_o,
    output logic [2:0]              state_o,
    output logic [7:0]              unlock_cnt_o
);

    localparam int unsigned TMR_W = 8;
    localparam int unsigned CNT_W = 8;
    localparam int unsigned MAG_W = ERROR_WIDTH + 1;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_PLL_RST = 3'd1,
        S_WARMUP  = 3'd2,
        S_ACQUIRE = 3'd3,
        S_TRACK   = 3'd4,
        S_FAIL    = 3'd5
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [TMR_W-1:0]   r_tmr, w_tmr_nxt;
    logic [CNT_W-1:0]   r_good, w_good_nxt;
    logic [CNT_W-1:0]   r_samp, w_samp_nxt;
    logic [CNT_W-1:0]   r_bad, w_bad_nxt;
    logic [7:0]         r_unl, w_unl_nxt;

    logic                    r_pll_reset, w_pll_reset;
    logic                    r_ring_en, w_ring_en;
    logic [KP_WIDTH-1:0]     r_kp, w_kp;
    logic [KI_WIDTH-1:0]     r_ki, w_ki;
    logic                    r_locked, w_locked;
    logic                    r_fail, w_fail;

    logic signed [MAG_W-1:0] w_ext;
    logic [MAG_W-1:0]        w_mag;
    logic                    w_small, w_big;

    // One extra bit so the most negative sample maps to its true magnitude.
    always_comb begin
        w_ext   = {err_if.error_i[ERROR_WIDTH-1], err_if.error_i};
        w_mag   = w_ext[MAG_W-1] ? MAG_W'(-w_ext) : MAG_W'(w_ext);
        w_small = (w_mag <= MAG_W'(ACQ_THRESH));
        w_big   = (w_mag >  MAG_W'(UNLOCK_THRESH));
    end

    always_ff @(posedge fpga_clk_i) begin
        if (!reset_i) begin
            r_state     <= S_IDLE;
            r_tmr       <= '0;
            r_good      <= '0;
            r_samp      <= '0;
            r_bad       <= '0;
            r_unl       <= '0;
            r_pll_reset <= 1'b1;
            r_ring_en   <= 1'b0;
            r_kp        <= KP_ACQ;
            r_ki        <= KI_ACQ;
            r_locked    <= 1'b0;
            r_fail      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_tmr       <= w_tmr_nxt;
            r_good      <= w_good_nxt;
            r_samp      <= w_samp_nxt;
            r_bad       <= w_bad_nxt;
            r_unl       <= w_unl_nxt;
            r_pll_reset <= w_pll_reset;
            r_ring_en   <= w_ring_en;
            r_kp        <= w_kp;
            r_ki        <= w_ki;
            r_locked    <= w_locked;
            r_fail      <= w_fail;
        end
    end

    // Dropping start_i overrides every other transition.
    always_comb begin
        w_state_nxt = r_state;
        w_tmr_nxt   = r_tmr;
        w_good_nxt  = r_good;
        w_samp_nxt  = r_samp;
        w_bad_nxt   = r_bad;
        w_unl_nxt   = r_unl;
        if (r_state != S_IDLE && !start_i) begin
            w_state_nxt = S_IDLE;
            w_tmr_nxt   = '0;
            w_good_nxt  = '0;
            w_samp_nxt  = '0;
            w_bad_nxt   = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        w_state_nxt = S_PLL_RST;
                        w_tmr_nxt   = '0;
                    end
                end
                S_PLL_RST: begin
                    if (r_tmr == TMR_W'(RST_CYCLES - 1)) begin
                        w_state_nxt = S_WARMUP;
                        w_tmr_nxt   = '0;
                    end else begin
                        w_tmr_nxt   = r_tmr + TMR_W'(1);
                    end
                end
                S_WARMUP: begin
                    if (r_tmr == TMR_W'(WARMUP_CYCLES - 1)) begin
                        w_state_nxt = S_ACQUIRE;
                        w_tmr_nxt   = '0;
                        w_good_nxt  = '0;
                        w_samp_nxt  = '0;
                    end else begin
                        w_tmr_nxt   = r_tmr + TMR_W'(1);
                    end
                end
                S_ACQUIRE: begin
                    if (err_if.error_valid_i) begin
                        w_good_nxt = w_small ? r_good + CNT_W'(1) : '0;
                        w_samp_nxt = r_samp + CNT_W'(1);
                        // Lock qualification takes priority over timeout.
                        if (w_good_nxt == CNT_W'(ACQ_COUNT)) begin
                            w_state_nxt = S_TRACK;
                            w_bad_nxt   = '0;
                        end else if (w_samp_nxt == CNT_W'(ACQ_TIMEOUT)) begin
                            w_state_nxt = S_FAIL;
                        end
                    end
                end
                S_TRACK: begin
                    if (err_if.error_valid_i) begin
                        w_bad_nxt = w_big ? r_bad + CNT_W'(1) : '0;
                        if (w_bad_nxt == CNT_W'(UNLOCK_COUNT)) begin
                            w_state_nxt = S_ACQUIRE;
                            w_good_nxt  = '0;
                            w_samp_nxt  = '0;
                            w_unl_nxt   = (r_unl == 8'hFF) ? r_unl : r_unl + 8'd1;
                        end
                    end
                end
                S_FAIL: begin
                    w_state_nxt = S_FAIL;
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    // Outputs decoded from the next state so they register alongside it.
    always_comb begin
        w_pll_reset = 1'b1;
        w_ring_en   = 1'b0;
        w_kp        = KP_ACQ;
        w_ki        = KI_ACQ;
        w_locked    = 1'b0;
        w_fail      = 1'b0;
        case (w_state_nxt)
            S_PLL_RST: begin
                w_ring_en   = 1'b1;
            end
            S_WARMUP, S_ACQUIRE: begin
                w_pll_reset = 1'b0;
                w_ring_en   = 1'b1;
            end
            S_TRACK: begin
                w_pll_reset = 1'b0;
                w_ring_en   = 1'b1;
                w_kp        = KP_TRK;
                w_ki        = KI_TRK;
                w_locked    = 1'b1;
            end
            S_FAIL: begin
                w_fail      = 1'b1;
            end
            default: begin
                w_pll_reset = 1'b1;
            end
        endcase
    end

    assign pll_reset_o   = r_pll_reset;
    assign ring_enable_o = r_ring_en;
    assign kp_o          = r_kp;
    assign ki_o          = r_ki;
    assign locked_o      = r_locked;
    assign fail_o        = r_fail;
    assign state_o       = r_state;
    assign unlock_cnt_o  = r_unl;

endmodule

// File: doc/adpll_lock_ctrl.md
ADPLL_LOCK_CTRL -- requirements
Module: adpll_lock_ctrl

Interface
REQ-001 Parameter ERROR_WIDTH, default 8, width of phase-detector error sample.
REQ-002 Parameter KP_WIDTH, default 4; KI_WIDTH, default 4: gain bus widths.
REQ-003 Parameters KP_ACQ=4'b0100, KI_ACQ=4'b0010 (wide acquisition gains); KP_TRK=4'b0010, KI_TRK=4'b0001 (narrow tracking gains).
REQ-004 Parameters RST_CYCLES=16, WARMUP_CYCLES=64 (fpga_clk_i cycles); ACQ_THRESH=2, UNLOCK_THRESH=8 (error magnitude); ACQ_COUNT=8, UNLOCK_COUNT=4, ACQ_TIMEOUT=255 (error samples).
REQ-005 fpga_clk_i  input  1  sole clock; all logic on rising edge.
REQ-006 reset_i  input  1  synchronous, active-low reset.
REQ-007 start_i  input  1  level request to run the loop; low returns to IDLE.
REQ-008 error_valid_i  input  1  one-cycle strobe, new error sample present.
REQ-009 error_i  input  ERROR_WIDTH  signed phase error, sampled only when error_valid_i=1.
REQ-010 pll_reset_o  output  1  active-high reset to the ring ADPLL datapath.
REQ-011 ring_enable_o  output  1  ring oscillator enable.
REQ-012 kp_o  output  KP_WIDTH; ki_o  output  KI_WIDTH: loop-filter gains.
REQ-013 locked_o  output  1; fail_o  output  1; state_o  output  3  encoded state.
REQ-014 unlock_cnt_o  output  8  saturating count of lock losses since reset.

Function
REQ-015 States and state_o encoding SHALL be IDLE=0, PLL_RST=1, WARMUP=2, ACQUIRE=3, TRACK=4, FAIL=5; all outputs registered.
REQ-016 IDLE: pll_reset_o=1, ring_enable_o=0, gains=ACQ values, locked_o=0, fail_o=0; start_i=1 -> PLL_RST next cycle.
REQ-017 PLL_RST: pll_reset_o=1, ring_enable_o=1 for exactly RST_CYCLES cycles, then -> WARMUP.
REQ-018 WARMUP: pll_reset_o=0, ring_enable_o=1, gains=ACQ; error samples ignored; after WARMUP_CYCLES cycles -> ACQUIRE.
REQ-019 Magnitude |error_i| SHALL be computed ERROR_WIDTH+1 bits wide so that the most negative value (-128) yields 128, never wrapping to a small value.
REQ-020 ACQUIRE: gains=ACQ; per valid sample, |e|<=ACQ_THRESH increments good counter else clears it; sample counter increments every valid sample.
REQ-021 ACQUIRE: good counter reaching ACQ_COUNT -> TRACK on the cycle after the qualifying strobe; sample counter reaching ACQ_TIMEOUT without lock -> FAIL; if both on same sample, TRACK wins.
REQ-022 TRACK: gains=TRK, locked_o=1 from the first TRACK cycle; per valid sample |e|>UNLOCK_THRESH increments bad counter else clears it.
REQ-023 TRACK: bad counter reaching UNLOCK_COUNT -> ACQUIRE next cycle, locked_o=0, unlock_cnt_o increments (saturates at 255); ACQUIRE counters cleared on entry.
REQ-024 FAIL: fail_o=1, ring_enable_o=0, pll_reset_o=1; remains until start_i=0 (-> IDLE); start_i must fall and rise again to retry.
REQ-025 start_i=0 in any non-IDLE state SHALL force IDLE next cycle, overriding all other transitions; counters cleared.
REQ-026 Gain change SHALL take effect on kp_o/ki_o the same cycle state_o changes; no intermediate values.
REQ-027 error_valid_i outside ACQUIRE/TRACK SHALL have no effect; strobe on the transition cycle into ACQUIRE is ignored.

Reset
REQ-028 reset_i=0 at a clock edge SHALL, on that edge, set state IDLE, pll_reset_o=1, ring_enable_o=0, kp_o=KP_ACQ, ki_o=KI_ACQ, locked_o=0, fail_o=0, unlock_cnt_o=0, all counters 0, regardless of current state.
REQ-029 Reset has no asynchronous effect; outputs hold until the next edge.

Verification
REQ-030 Reset then start_i=1 -> state_o 1 for 16 cycles, 2 for 64 cycles, then 3; pll_reset_o falls entering WARMUP.
REQ-031 In ACQUIRE, 8 strobes with error=+1/-2 -> state_o=4, locked_o=1, kp_o=0010, ki_o=0001; 7 good plus 1 error=+3 -> stays ACQUIRE, counter restarts.
REQ-032 In TRACK, 4 consecutive strobes error=-9 -> ACQUIRE, locked_o=0, unlock_cnt_o=1; 3 bad then error=0 -> stays TRACK.
REQ-033 In ACQUIRE, 255 strobes error=-128 -> FAIL, fail_o=1, ring_enable_o=0 (verifies -128 not treated as small).
REQ-034 start_i dropped mid-TRACK -> IDLE next cycle, unlock_cnt_o retained; reset_i=0 mid-WARMUP -> IDLE and all outputs at reset values next edge.
